dds_sweep_ctrl: RTL and testbench

//  Frequency sweep/hop sequencer that drives the dds block's i_increment/i_update pair.

---
 rtl/dds_sweep_ctrl_pkg.sv | 33 +++
 rtl/dds_sweep_ctrl_if.sv | 33 +++
 rtl/dds_sweep_ctrl_dwell_timer.sv | 42 ++++
 rtl/dds_sweep_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types for the dds sweep controller: FSM states, sweep modes and the
// default widths used by the controller and its interface.
package dds_sweep_ctrl_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_REPEAT = 2'd1,
    MODE_UPDOWN = 2'd2
  } mode_e;

  // The reserved encoding 3 behaves as a single sweep.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'd1:    m = MODE_REPEAT;
      2'd2:    m = MODE_UPDOWN;
      default: m = MODE_SINGLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Config/strobe inputs and dds-facing outputs of one sweep controller.
//
// Handshake: there is no back-pressure. i_start and i_abort are one-cycle
// strobes sampled on the rising clock edge; the config fields only need to be
// valid in the cycle i_start is high. o_update is a one-cycle strobe and
// o_increment is valid in that same cycle; the dds must take it unconditionally.
interface dds_sweep_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 16
);
  logic          i_ce;
  logic          i_start;
  logic          i_abort;
  logic [1:0]    i_mode;
  logic [AW-2:0] i_f_start;
  logic [AW-2:0] i_f_stop;
  logic [AW-2:0] i_f_step;
  logic [DW-1:0] i_dwell;
  logic [AW-2:0] o_increment;
  logic          o_update;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_ce, i_start, i_abort, i_mode, i_f_start, i_f_stop, i_f_step, i_dwell,
    input  o_increment, o_update, o_busy, o_done
  );

  modport slave (
    input  i_ce, i_start, i_abort, i_mode, i_f_start, i_f_stop, i_f_step, i_dwell,
    output o_increment, o_update, o_busy, o_done
  );
endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell down-counter: loaded with max(dwell,1), decrements on enabled cycles,
// and flags expiry during the enabled cycle that would take it from 1 to 0.
module dds_dwell_timer #(
  parameter int dwell_width = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic                   i_ce,
  input  logic [dwell_width-1:0] i_dwell,
  output logic                   o_expire
);

  localparam logic [dwell_width-1:0] ONE = dwell_width'(1);

  logic [dwell_width-1:0] count_q, count_d;

  // Next count: clear beats load, load beats decrement.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = (i_dwell == '0) ? ONE : i_dwell;
    end else if (i_ce && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  assign o_expire = i_ce && (count_q == ONE);

  // Count register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer feeding a dds increment/update pair. Steps the
// increment from a start value toward a stop value, holding each value for a
// programmable number of enabled cycles, in single, sawtooth or triangle mode.
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int accumulator_width = DEF_AW,
  parameter int dwell_width       = DEF_DW
) (
  input  logic            i_clk,
  input  logic            i_reset,
  dds_sweep_ctrl_if.slave bus,
  output state_e          o_dbg_state
);

  localparam int IW = accumulator_width - 1;
  localparam int DW = dwell_width;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [IW-1:0] start_q, start_d;
  logic [IW-1:0] stop_q, stop_d;
  logic [IW-1:0] step_q, step_d;
  logic [IW-1:0] inc_q, inc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          dir_down_q, dir_down_d;
  logic          tgt_stop_q, tgt_stop_d;
  logic          upd_q, upd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tmr_load, tmr_clear, tmr_ce, tmr_expire;
  logic [IW-1:0] target, rev_target, fwd_next, rev_next;

  // One step from cur toward tgt, computed one bit wider so that a carry or
  // borrow lands on tgt instead of wrapping around past it.
  function automatic logic [IW-1:0] step_toward(input logic [IW-1:0] cur,
                                                input logic [IW-1:0] tgt,
                                                input logic [IW-1:0] stp,
                                                input logic          down);
    logic [IW:0]   wide;
    logic [IW-1:0] res;
    if (down) begin
      wide = {1'b0, cur} - {1'b0, stp};
      res  = (wide[IW] || (wide[IW-1:0] < tgt)) ? tgt : wide[IW-1:0];
    end else begin
      wide = {1'b0, cur} + {1'b0, stp};
      res  = (wide >= {1'b0, tgt}) ? tgt : wide[IW-1:0];
    end
    return res;
  endfunction

  // Current endpoint being approached, and the one used after a triangle turn.
  assign target     = tgt_stop_q ? stop_q : start_q;
  assign rev_target = tgt_stop_q ? start_q : stop_q;
  assign fwd_next   = step_toward(inc_q, target, step_q, dir_down_q);
  assign rev_next   = step_toward(inc_q, rev_target, step_q, !dir_down_q);
  assign tmr_ce     = bus.i_ce && (state_q == ST_DWELL);

  // Next-state, config latch and registered-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    dir_down_d = dir_down_q;
    tgt_stop_d = tgt_stop_q;
    inc_d      = inc_q;
    upd_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;
    if (bus.i_abort) begin
      // Abort wins over everything, including a simultaneous start.
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            mode_d     = decode_mode(bus.i_mode);
            start_d    = bus.i_f_start;
            stop_d     = bus.i_f_stop;
            step_d     = bus.i_f_step;
            dwell_d    = bus.i_dwell;
            dir_down_d = (bus.i_f_stop < bus.i_f_start);
            tgt_stop_d = 1'b1;
            inc_d      = bus.i_f_start;
            upd_d      = 1'b1;
            busy_d     = 1'b1;
            state_d    = ST_LOAD;
          end
        end
        ST_LOAD, ST_STEP: begin
          // The update strobe is visible this cycle; arm the dwell.
          tmr_load = 1'b1;
          state_d  = ST_DWELL;
        end
        ST_DWELL: begin
          if (tmr_expire) begin
            if (inc_q == target) begin
              case (mode_q)
                MODE_REPEAT: begin
                  inc_d   = start_q;
                  upd_d   = 1'b1;
                  state_d = ST_LOAD;
                end
                MODE_UPDOWN: begin
                  dir_down_d = !dir_down_q;
                  tgt_stop_d = !tgt_stop_q;
                  inc_d      = rev_next;
                  upd_d      = 1'b1;
                  state_d    = ST_STEP;
                end
                default: begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_DONE;
                end
              endcase
            end else if (step_q == '0) begin
              // Zero step can never reach the target: keep dwelling silently.
              tmr_load = 1'b1;
            end else begin
              inc_d   = fwd_next;
              upd_d   = 1'b1;
              state_d = ST_STEP;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, config and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_SINGLE;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      dir_down_q <= 1'b0;
      tgt_stop_q <= 1'b1;
      inc_q      <= '0;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      dir_down_q <= dir_down_d;
      tgt_stop_q <= tgt_stop_d;
      inc_q      <= inc_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  dds_dwell_timer #(
    .dwell_width(DW)
  ) u_dwell (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (tmr_clear),
    .i_load  (tmr_load),
    .i_ce    (tmr_ce),
    .i_dwell (dwell_q),
    .o_expire(tmr_expire)
  );

  assign bus.o_increment = inc_q;
  assign bus.o_update    = upd_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps, a sequence-level reference model
// checked every cycle, and literal expectations for each scenario.
module tb_dds_sweep_ctrl;
  import dds_sweep_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int IW = AW - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  state_e dbg_state;

  dds_sweep_ctrl #(
    .accumulator_width(AW),
    .dwell_width      (DW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  bit ce_toggle = 1'b0;
  initial begin
    bus.i_ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_ce = ce_toggle ? !bus.i_ce : 1'b1;
    end
  end

  // ---------------- scoreboard / checks ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Reference model: the full list of values a sweep must emit, plus timing.
  logic [IW-1:0] exp_q[$];
  bit            m_active = 1'b0;
  bit            m_single = 1'b1;
  int            m_cnt    = 0;
  int            m_dwell  = 1;
  bit            e_upd    = 1'b0;
  bit            e_busy   = 1'b0;
  bit            e_done   = 1'b0;
  logic [IW-1:0] e_inc    = '0;

  // Observed history for literal checks.
  logic [IW-1:0] upd_val[$];
  int            upd_cyc[$];
  int            done_cyc = -1;
  int            start_cyc = 0;
  logic [IW-1:0] lit_q[$];

  // Values emitted by a sweep, from the stepping rules in plain integer math.
  task automatic build_sweep(input logic [IW-1:0] s_in, input logic [IW-1:0] e_in,
                             input logic [IW-1:0] st_in, input logic [1:0] md);
    longint s, e, st, v, tgt;
    s  = longint'(s_in);
    e  = longint'(e_in);
    st = longint'(st_in);
    exp_q.delete();
    m_single = !(md == 2'd1 || md == 2'd2);
    if (st == 0 && s != e) begin
      exp_q.push_back(s_in);
      m_single = 1'b0;
      return;
    end
    v   = s;
    tgt = e;
    exp_q.push_back(IW'(v));
    while (exp_q.size() < 64) begin
      if (v == tgt) begin
        if (m_single) break;
        if (md == 2'd1 || s == e) begin
          v = s;
          exp_q.push_back(IW'(v));
          continue;
        end
        tgt = (tgt == e) ? s : e;
      end
      if (tgt > v) v = (v + st > tgt) ? tgt : v + st;
      else         v = (v - st < tgt) ? tgt : v - st;
      exp_q.push_back(IW'(v));
    end
  endtask

  // Advance the model by one cycle using the inputs the DUT samples next edge.
  task automatic model_advance();
    bit cur_upd, cur_done;
    cur_upd  = e_upd;
    cur_done = e_done;
    e_upd    = 1'b0;
    e_done   = 1'b0;
    if (bus.i_abort) begin
      m_active = 1'b0;
      e_busy   = 1'b0;
      exp_q.delete();
    end else if (!m_active) begin
      if (bus.i_start) begin
        build_sweep(bus.i_f_start, bus.i_f_stop, bus.i_f_step, bus.i_mode);
        m_dwell  = (bus.i_dwell == '0) ? 1 : int'(bus.i_dwell);
        m_active = 1'b1;
        m_cnt    = 0;
        e_upd    = 1'b1;
        e_inc    = exp_q.pop_front();
        e_busy   = 1'b1;
      end
    end else if (cur_done) begin
      m_active = 1'b0;
    end else if (!cur_upd) begin
      if (bus.i_ce) m_cnt++;
      if (m_cnt >= m_dwell) begin
        m_cnt = 0;
        if (exp_q.size() > 0) begin
          e_upd = 1'b1;
          e_inc = exp_q.pop_front();
        end else if (m_single) begin
          e_done = 1'b1;
          e_busy = 1'b0;
        end
      end
    end
  endtask

  // Compare process: mid-cycle, every cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_active = 1'b0;
      exp_q.delete();
      e_upd  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_inc  = '0;
    end
    check("o_update",    64'(bus.o_update),    64'(e_upd));
    check("o_busy",      64'(bus.o_busy),      64'(e_busy));
    check("o_done",      64'(bus.o_done),      64'(e_done));
    check("o_increment", 64'(bus.o_increment), 64'(e_inc));
    if (bus.o_update === 1'b1) begin
      upd_val.push_back(bus.o_increment);
      upd_cyc.push_back(cyc);
    end
    if (bus.o_done === 1'b1) done_cyc = cyc;
    if (!rst) model_advance();
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [IW-1:0] s, input logic [IW-1:0] e,
                          input logic [IW-1:0] st, input logic [DW-1:0] dw,
                          input logic [1:0] md);
    @(posedge clk);
    #1;
    upd_val.delete();
    upd_cyc.delete();
    done_cyc      = -1;
    bus.i_f_start = s;
    bus.i_f_stop  = e;
    bus.i_f_step  = st;
    bus.i_dwell   = dw;
    bus.i_mode    = md;
    bus.i_start   = 1'b1;
    start_cyc     = cyc;
    @(posedge clk);
    #1;
    bus.i_start   = 1'b0;
    // Config must have been latched; scramble it.
    bus.i_f_start = IW'($urandom);
    bus.i_f_stop  = IW'($urandom);
    bus.i_f_step  = IW'($urandom_range(0, 100));
    bus.i_dwell   = DW'($urandom_range(0, 7));
    bus.i_mode    = 2'($urandom_range(0, 3));
  endtask

  task automatic pulse_start(input logic [IW-1:0] s, input logic [IW-1:0] e,
                             input logic [IW-1:0] st, input bit with_abort);
    @(posedge clk);
    #1;
    bus.i_f_start = s;
    bus.i_f_stop  = e;
    bus.i_f_step  = st;
    bus.i_dwell   = DW'(1);
    bus.i_mode    = 2'd0;
    bus.i_start   = 1'b1;
    bus.i_abort   = with_abort;
    @(posedge clk);
    #1;
    bus.i_start   = 1'b0;
    bus.i_abort   = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk);
    #1;
    bus.i_abort = 1'b1;
    @(posedge clk);
    #1;
    bus.i_abort = 1'b0;
  endtask

  task automatic wait_updates(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (upd_val.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (upd_val.size() < n) timeout_fail(name);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (done_cyc < 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cyc < 0) timeout_fail(name);
  endtask

  function automatic int upd_at(input int i);
    return (i < upd_cyc.size()) ? upd_cyc[i] : -1000;
  endfunction

  // Observed values against lit_q, and fixed spacing when spacing > 0.
  task automatic check_seq(input string name, input int spacing);
    logic [IW-1:0] got;
    check({name, "_count"}, 64'(upd_val.size()), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++) begin
      got = (i < upd_val.size()) ? upd_val[i] : 'x;
      check($sformatf("%s_val%0d", name, i), 64'(got), 64'(lit_q[i]));
      if (spacing > 0 && i > 0)
        check($sformatf("%s_gap%0d", name, i), 64'(upd_at(i) - upd_at(i - 1)), 64'(spacing));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_start   = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_mode    = 2'd0;
    bus.i_f_start = '0;
    bus.i_f_stop  = '0;
    bus.i_f_step  = '0;
    bus.i_dwell   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_increment", 64'(bus.o_increment), 64'd0);
    check("rst_update",    64'(bus.o_update),    64'd0);
    check("rst_busy",      64'(bus.o_busy),      64'd0);
    check("rst_done",      64'(bus.o_done),      64'd0);
    check("rst_state",     64'(dbg_state),       64'(ST_IDLE));
    @(negedge clk);
    #1;
    rst = 1'b0;

    // 1: single upward sweep, dwell 3
    do_start(31'd100, 31'd130, 31'd10, 16'd3, 2'd0);
    wait_done(60, "t1_done");
    check("t1_busy_at_done", 64'(bus.o_busy), 64'd0);
    lit_q = '{31'd100, 31'd110, 31'd120, 31'd130};
    check_seq("t1", 4);
    check("t1_latency", 64'(upd_at(0) - start_cyc), 64'd1);
    check("t1_done_gap", 64'(done_cyc - upd_at(3)), 64'd4);

    // 2: downward sweep with clamp, reserved mode acts as single
    do_start(31'd1000, 31'd975, 31'd10, 16'd1, 2'd3);
    wait_done(40, "t2_done");
    lit_q = '{31'd1000, 31'd990, 31'd980, 31'd975};
    check_seq("t2", 2);
    check("t2_done_gap", 64'(done_cyc - upd_at(3)), 64'd2);

    // 3: top-of-range sweep must clamp rather than wrap
    do_start(31'd2147483628, 31'd2147483647, 31'd15, 16'd1, 2'd0);
    wait_done(40, "t3_done");
    lit_q = '{31'd2147483628, 31'd2147483643, 31'd2147483647};
    check_seq("t3", 2);

    // 3b: bottom-of-range sweep must clamp rather than wrap
    do_start(31'd5, 31'd0, 31'd10, 16'd1, 2'd0);
    wait_done(40, "t3b_done");
    lit_q = '{31'd5, 31'd0};
    check_seq("t3b", 2);

    // Sawtooth repeat
    do_start(31'd0, 31'd20, 31'd10, 16'd1, 2'd1);
    wait_updates(5, 40, "rep_updates");
    lit_q = '{31'd0, 31'd10, 31'd20, 31'd0, 31'd10};
    check_seq("rep", 2);
    do_abort();

    // 4: triangle, then abort mid-dwell
    do_start(31'd0, 31'd20, 31'd10, 16'd2, 2'd2);
    wait_updates(7, 60, "t4_updates");
    lit_q = '{31'd0, 31'd10, 31'd20, 31'd10, 31'd0, 31'd10, 31'd20};
    check_seq("t4", 3);
    do_abort();
    check("t4_abort_busy",  64'(bus.o_busy),      64'd0);
    check("t4_abort_hold",  64'(bus.o_increment), 64'd20);
    check("t4_abort_state", 64'(dbg_state),       64'(ST_IDLE));
    repeat (8) @(negedge clk);
    #1;
    check("t4_no_done",      64'(done_cyc),       64'(-1));
    check("t4_no_more_upd",  64'(upd_val.size()), 64'd7);

    // Zero step: one update then silent dwelling until abort
    do_start(31'd5, 31'd9, 31'd0, 16'd1, 2'd0);
    repeat (12) @(negedge clk);
    #1;
    lit_q = '{31'd5};
    check_seq("zstep", 0);
    check("zstep_busy", 64'(bus.o_busy), 64'd1);
    check("zstep_done", 64'(done_cyc),   64'(-1));
    do_abort();

    // 5: ce gating, start while busy, start+abort together
    ce_toggle = 1'b1;
    do_start(31'd0, 31'd30, 31'd10, 16'd2, 2'd0);
    repeat (3) @(posedge clk);
    pulse_start(31'd1000, 31'd2000, 31'd5, 1'b0);
    wait_done(80, "t5_done");
    lit_q = '{31'd0, 31'd10, 31'd20, 31'd30};
    check_seq("t5", 0);
    for (int i = 1; i < 4; i++) begin
      int gap;
      gap = upd_at(i) - upd_at(i - 1);
      check($sformatf("t5_gap%0d_in_4_5", i), 64'(gap == 4 || gap == 5), 64'd1);
    end
    ce_toggle = 1'b0;
    upd_val.delete();
    upd_cyc.delete();
    pulse_start(31'd40, 31'd50, 31'd5, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    check("t5_startabort_upd",   64'(upd_val.size()), 64'd0);
    check("t5_startabort_busy",  64'(bus.o_busy),     64'd0);
    check("t5_startabort_state", 64'(dbg_state),      64'(ST_IDLE));

    // 6: dwell 0 acts as 1, async reset mid-sweep, then recovery
    do_start(31'd500, 31'd600, 31'd50, 16'd0, 2'd0);
    wait_updates(2, 20, "t6_updates");
    lit_q = '{31'd500, 31'd550};
    check_seq("t6", 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_increment", 64'(bus.o_increment), 64'd0);
    check("t6_rst_update",    64'(bus.o_update),    64'd0);
    check("t6_rst_busy",      64'(bus.o_busy),      64'd0);
    check("t6_rst_state",     64'(dbg_state),       64'(ST_IDLE));
    @(negedge clk);
    #1;
    rst = 1'b0;
    do_start(31'd77, 31'd77, 31'd5, 16'd3, 2'd0);
    wait_done(30, "t6_eq_done");
    lit_q = '{31'd77};
    check_seq("t6_eq", 0);
    check("t6_eq_latency",  64'(upd_at(0) - start_cyc), 64'd1);
    check("t6_eq_done_gap", 64'(done_cyc - upd_at(0)),  64'd4);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
